// File: rtl/seq_add_sub_if.sv
// Operand/result bundle for the sliced add/subtract unit.
// The master side issues operations; the slave side is the arithmetic unit.
interface seq_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, sub, cin,
    input  ready, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, a, b, sub, cin,
    output ready, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, with the carry
// registered between slices so the ripple chain never spans more than CHUNK bits.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | one slice per edge, LSB slice first
// DONE  | one-cycle done pulse, ready=1, may accept back-to-back
module seq_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_add_sub_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_add_sub: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             ready;
  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_full;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic             carry_msb;
  logic [WIDTH-1:0] sum_nxt;

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign accept = bus.start && ready;
  assign last   = (cnt_q == CW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice mux: operand slice in, updated full-width sum out.
  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    sum_nxt = sum_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl                       = a_q[k*CHUNK +: CHUNK];
        b_sl                       = b_q[k*CHUNK +: CHUNK];
        sum_nxt[k*CHUNK +: CHUNK]  = slice_s;
      end
    end
  end

  assign slice_full = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  assign slice_s    = slice_full[CHUNK-1:0];
  assign slice_c    = slice_full[CHUNK];
  // Carry into the slice MSB recovered from the MSB's own sum bit.
  assign carry_msb  = slice_s[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub ? 1'b1 : bus.cin;
    end else if (state_q == RUN) begin
      sum_q   <= sum_nxt;
      carry_q <= slice_c;
      if (last) begin
        cout_q <= slice_c;
        ovf_q  <= carry_msb ^ slice_c;
        zero_q <= (sum_nxt == '0);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.ready = ready;
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;

endmodule
